// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory responder: FSM states,
// address regions and the MMIO register map.
package data_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } stateT;

    typedef enum logic [1:0] {
        REGION_RAM  = 2'd0,
        REGION_MMIO = 2'd1,
        REGION_OOR  = 2'd2
    } regionT;

    localparam logic [15:0] MMIO_LED_OFF = 16'h0000;
    localparam logic [15:0] MMIO_SW_OFF  = 16'h0004;

    localparam int CNT_WIDTH = 4;

    // MMIO wins over RAM; anything above the RAM word range is out-of-range.
    function automatic regionT decodeRegion(input logic [31:0] addr,
                                            input logic [15:0] mmioHi,
                                            input int unsigned addrWidth);
        if (addr[31:16] == mmioHi) begin
            return REGION_MMIO;
        end
        if ((addr >> (addrWidth + 2)) == 32'd0) begin
            return REGION_RAM;
        end
        return REGION_OOR;
    endfunction

endpackage

// File: rtl/data_mem_responder_bram.sv
// Single-port word RAM with registered read; contents are never reset.
module data_bram #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] memArray [2**ADDR_WIDTH];
    logic [31:0] rdataReg;

    always_ff @(posedge clk) begin
        if (we) begin
            memArray[addr] <= wdata;
        end
        if (re) begin
            rdataReg <= memArray[addr];
        end
    end

    assign rdata = rdataReg;

endmodule

// File: rtl/data_mem_responder.sv
// DCache-side memory responder: one word request at a time, served from
// block RAM or the LED/switch MMIO window after a fixed latency.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int          ADDR_WIDTH = 14,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReq,
    input  logic        MemWe,
    input  logic [31:0] MemAddr,
    input  logic [31:0] MemWriteData,
    output logic [31:0] MemData,
    output logic        MemReady,
    output logic        MemBusy,
    input  logic [15:0] Switches,
    output logic [15:0] Leds
);

    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(LATENCY - 1);
    localparam logic [15:0]          MMIO_HI  = MMIO_BASE[31:16];

    stateT                 stateReg;
    logic [CNT_WIDTH-1:0]  cntReg;
    regionT                regionReg;
    logic                  weReg;
    logic [ADDR_WIDTH-1:0] wordAddrReg;
    logic [13:0]           mmioOffReg;
    logic [31:0]           wdataReg;
    logic                  memReadyReg;
    logic                  selRamReg;
    logic [31:0]           auxDataReg;
    logic [15:0]           ledsReg;
    logic [15:0]           swMetaReg;
    logic [15:0]           swSyncReg;

    logic                  commit;
    logic                  ramWe;
    logic                  ramRe;
    logic [31:0]           ramRdata;
    logic [31:0]           mmioRdata;
    logic [1:0]            unusedAddrBits;

    assign unusedAddrBits = MemAddr[1:0];

    // Last WAIT cycle: the edge ending it commits writes and captures reads.
    // Reset suppresses the RAM strobes so a reset on that edge loses the write.
    assign commit = (stateReg == ST_WAIT) && (cntReg == '0);
    assign ramWe  = commit && rst && weReg  && (regionReg == REGION_RAM);
    assign ramRe  = commit && rst && !weReg && (regionReg == REGION_RAM);

    data_bram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) uBram (
        .clk  (clk),
        .we   (ramWe),
        .re   (ramRe),
        .addr (wordAddrReg),
        .wdata(wdataReg),
        .rdata(ramRdata)
    );

    always_comb begin
        mmioRdata = '0;
        if (mmioOffReg == MMIO_LED_OFF[15:2]) begin
            mmioRdata = {16'h0000, ledsReg};
        end else if (mmioOffReg == MMIO_SW_OFF[15:2]) begin
            mmioRdata = {16'h0000, swSyncReg};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            swMetaReg <= '0;
            swSyncReg <= '0;
        end else begin
            swMetaReg <= Switches;
            swSyncReg <= swMetaReg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stateReg    <= ST_IDLE;
            cntReg      <= '0;
            regionReg   <= REGION_RAM;
            weReg       <= 1'b0;
            wordAddrReg <= '0;
            mmioOffReg  <= '0;
            wdataReg    <= '0;
            memReadyReg <= 1'b0;
            selRamReg   <= 1'b0;
            auxDataReg  <= '0;
            ledsReg     <= '0;
        end else begin
            memReadyReg <= 1'b0;
            case (stateReg)
                ST_IDLE: begin
                    if (MemReq) begin
                        weReg       <= MemWe;
                        wordAddrReg <= MemAddr[ADDR_WIDTH+1:2];
                        mmioOffReg  <= MemAddr[15:2];
                        wdataReg    <= MemWriteData;
                        regionReg   <= decodeRegion(MemAddr, MMIO_HI, ADDR_WIDTH);
                        cntReg      <= CNT_LOAD;
                        stateReg    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cntReg == '0) begin
                        stateReg    <= ST_RESP;
                        memReadyReg <= 1'b1;
                        if (weReg) begin
                            selRamReg  <= 1'b0;
                            auxDataReg <= '0;
                            if (regionReg == REGION_MMIO &&
                                mmioOffReg == MMIO_LED_OFF[15:2]) begin
                                ledsReg <= wdataReg[15:0];
                            end
                        end else begin
                            // RAM data arrives from the BRAM output register
                            selRamReg  <= (regionReg == REGION_RAM);
                            auxDataReg <= (regionReg == REGION_MMIO) ? mmioRdata : 32'h0;
                        end
                    end else begin
                        cntReg <= cntReg - 1'b1;
                    end
                end
                ST_RESP: begin
                    stateReg <= ST_IDLE;
                end
                default: begin
                    stateReg <= ST_IDLE;
                end
            endcase
        end
    end

    assign MemData  = selRamReg ? ramRdata : auxDataReg;
    assign MemReady = memReadyReg;
    assign MemBusy  = (stateReg != ST_IDLE);
    assign Leds     = ledsReg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (LATENCY 2 and 1) checked every
// cycle against a transaction-level model, plus directed literal expectations.
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic        memReq       [2];
    logic        memWe        [2];
    logic [31:0] memAddr      [2];
    logic [31:0] memWriteData [2];
    logic [31:0] memData      [2];
    logic        memReady     [2];
    logic        memBusy      [2];
    logic [15:0] switches     [2];
    logic [15:0] leds         [2];

    int checks = 0;
    int errors = 0;

    data_mem_responder #(
        .ADDR_WIDTH(14), .LATENCY(2), .MMIO_BASE(32'hFFFF_0000)
    ) dut0 (
        .clk(clk), .rst(rst), .MemReq(memReq[0]), .MemWe(memWe[0]),
        .MemAddr(memAddr[0]), .MemWriteData(memWriteData[0]),
        .MemData(memData[0]), .MemReady(memReady[0]), .MemBusy(memBusy[0]),
        .Switches(switches[0]), .Leds(leds[0])
    );

    data_mem_responder #(
        .ADDR_WIDTH(14), .LATENCY(1), .MMIO_BASE(32'hFFFF_0000)
    ) dut1 (
        .clk(clk), .rst(rst), .MemReq(memReq[1]), .MemWe(memWe[1]),
        .MemAddr(memAddr[1]), .MemWriteData(memWriteData[1]),
        .MemData(memData[1]), .MemReady(memReady[1]), .MemBusy(memBusy[1]),
        .Switches(switches[1]), .Leds(leds[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int latOf(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    // Transaction-level model: a request accepted at edge A responds at edge
    // A+L and the responder is free again from edge A+L+2.
    int          edgeN = 0;
    bit          pending  [2];
    int          accEdge  [2];
    bit          tWe      [2];
    logic [31:0] tAddr    [2];
    logic [31:0] tWd      [2];
    logic [31:0] expData  [2];
    bit          expKnown [2];
    bit          expReady [2];
    logic [15:0] expLeds  [2];
    logic [15:0] swOld    [2];
    logic [15:0] swNew    [2];
    logic [31:0] memModel [int];

    task automatic commitTxn(input int i, input logic [15:0] swVis);
        logic [31:0] a;
        int          key;
        bit          isMmio;
        bit          isRam;
        a      = tAddr[i];
        key    = i * 65536 + int'(a[15:2]);
        isMmio = (a[31:16] == 16'hFFFF);
        isRam  = (a[31:16] == 16'h0000);
        expKnown[i] = 1'b1;
        expData[i]  = 32'h0;
        if (tWe[i]) begin
            if (isRam) memModel[key] = tWd[i];
            else if (isMmio && a[15:2] == 14'd0) expLeds[i] = tWd[i][15:0];
        end else if (isRam) begin
            if (memModel.exists(key)) expData[i] = memModel[key];
            else expKnown[i] = 1'b0;
        end else if (isMmio) begin
            if (a[15:2] == 14'd0) expData[i] = {16'h0, expLeds[i]};
            else if (a[15:2] == 14'd1) expData[i] = {16'h0, swVis};
        end
    endtask

    task automatic stepModel(input int i);
        int          lat;
        logic [15:0] swVis;
        lat = latOf(i);
        if (!rst) begin
            pending[i]  = 1'b0;
            expReady[i] = 1'b0;
            expLeds[i]  = 16'h0;
            expData[i]  = 32'h0;
            expKnown[i] = 1'b1;
            swOld[i]    = 16'h0;
            swNew[i]    = 16'h0;
        end else begin
            swVis       = swOld[i];
            swOld[i]    = swNew[i];
            swNew[i]    = switches[i];
            expReady[i] = 1'b0;
            if (pending[i]) begin
                if (edgeN == accEdge[i] + lat) begin
                    commitTxn(i, swVis);
                    expReady[i] = 1'b1;
                end else if (edgeN == accEdge[i] + lat + 1) begin
                    pending[i] = 1'b0;
                end
            end else if (memReq[i]) begin
                pending[i] = 1'b1;
                accEdge[i] = edgeN;
                tWe[i]     = memWe[i];
                tAddr[i]   = memAddr[i];
                tWd[i]     = memWriteData[i];
            end
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        edgeN++;
        for (int i = 0; i < 2; i++) begin
            stepModel(i);
            check($sformatf("ready%0d@%0d", i, edgeN), {31'b0, memReady[i]}, {31'b0, expReady[i]});
            check($sformatf("busy%0d@%0d", i, edgeN), {31'b0, memBusy[i]}, {31'b0, pending[i]});
            check($sformatf("leds%0d@%0d", i, edgeN), {16'b0, leds[i]}, {16'b0, expLeds[i]});
            if (expKnown[i]) begin
                check($sformatf("data%0d@%0d", i, edgeN), memData[i], expData[i]);
            end
        end
    end

    logic [31:0] rd;
    int          rAt;
    int          bc;

    task automatic txn(input int i, input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input bit setSw, input logic [15:0] sw,
                       output logic [31:0] rdata, output int readyAt, output int busyCnt);
        @(negedge clk);
        memReq[i]       = 1'b1;
        memWe[i]        = we;
        memAddr[i]      = a;
        memWriteData[i] = wd;
        if (setSw) switches[i] = sw;
        readyAt = -1;
        busyCnt = 0;
        rdata   = 32'h0;
        for (int n = 1; n <= 40 && readyAt < 0; n++) begin
            @(negedge clk);
            if (n == 1) memReq[i] = 1'b0;
            if (memBusy[i]) busyCnt++;
            if (memReady[i]) begin
                readyAt = n;
                rdata   = memData[i];
            end
        end
        check($sformatf("timeout%0d_%h", i, a), {31'b0, readyAt < 0}, 32'h0);
        $display("txn inst=%0d we=%0b addr=%h wdata=%h rdata=%h readyAt=%0d busy=%0d",
                 i, we, a, wd, rdata, readyAt, busyCnt);
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            memReq[i] = 1'b0; memWe[i] = 1'b0; memAddr[i] = 32'h0; memWriteData[i] = 32'h0;
        end
        switches[0] = 16'h1234;
        switches[1] = 16'h0042;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, memReady[0]}, 32'h0);
        check("rst_busy", {31'b0, memBusy[0]}, 32'h0);
        check("rst_data", memData[0], 32'h0);
        check("rst_leds", {16'b0, leds[0]}, 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Latency/busy window on an untouched location
        txn(0, 0, 32'h0000_0010, 32'h0, 0, 16'h0, rd, rAt, bc);
        check("rd10_readyAt", rAt, 3);
        check("rd10_busyCycles", bc, 3);

        txn(0, 1, 32'h0000_0100, 32'hDEAD_BEEF, 0, 16'h0, rd, rAt, bc);
        check("wr100_data", rd, 32'h0);
        txn(0, 0, 32'h0000_0103, 32'h0, 0, 16'h0, rd, rAt, bc);
        check("rd103", rd, 32'hDEAD_BEEF);

        // MMIO window
        txn(0, 1, 32'hFFFF_0000, 32'h0000_A5A5, 0, 16'h0, rd, rAt, bc);
        check("leds_a5a5", {16'b0, leds[0]}, 32'h0000_A5A5);
        txn(0, 0, 32'hFFFF_0000, 32'h0, 0, 16'h0, rd, rAt, bc);
        check("rd_leds", rd, 32'h0000_A5A5);
        txn(0, 0, 32'hFFFF_0004, 32'h0, 0, 16'h0, rd, rAt, bc);
        check("rd_sw1234", rd, 32'h0000_1234);
        txn(0, 1, 32'hFFFF_0004, 32'h0000_FFFF, 0, 16'h0, rd, rAt, bc);
        check("wr_sw_noeffect", {16'b0, leds[0]}, 32'h0000_A5A5);
        txn(0, 0, 32'hFFFF_0004, 32'h0, 1, 16'hBEEF, rd, rAt, bc);
        check("rd_sw_2cyc", rd, 32'h0000_BEEF);
        txn(0, 0, 32'hFFFF_0008, 32'h0, 0, 16'h0, rd, rAt, bc);
        check("rd_mmio_other", rd, 32'h0);

        // RAM boundaries and out-of-range
        txn(0, 1, 32'h0000_0000, 32'h5555_AAAA, 0, 16'h0, rd, rAt, bc);
        txn(0, 1, 32'h0000_FFFC, 32'h1357_9BDF, 0, 16'h0, rd, rAt, bc);
        txn(0, 0, 32'h0010_0000, 32'h0, 0, 16'h0, rd, rAt, bc);
        check("rd_oor", rd, 32'h0);
        check("rd_oor_readyAt", rAt, 3);
        txn(0, 1, 32'h0010_0000, 32'h1234_5678, 0, 16'h0, rd, rAt, bc);
        txn(0, 1, 32'h0001_0000, 32'hFFFF_FFFF, 0, 16'h0, rd, rAt, bc);
        txn(0, 0, 32'h0000_0000, 32'h0, 0, 16'h0, rd, rAt, bc);
        check("rd0_after_oor", rd, 32'h5555_AAAA);
        txn(0, 0, 32'h0000_FFFC, 32'h0, 0, 16'h0, rd, rAt, bc);
        check("rdFFFC", rd, 32'h1357_9BDF);

        // Reset on the commit edge of a write
        @(negedge clk);
        memReq[0] = 1'b1; memWe[0] = 1'b1; memAddr[0] = 32'h0000_0100; memWriteData[0] = 32'hCAFE_F00D;
        @(negedge clk);
        memReq[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_ready", {31'b0, memReady[0]}, 32'h0);
        check("rstmid_busy", {31'b0, memBusy[0]}, 32'h0);
        check("rstmid_leds", {16'b0, leds[0]}, 32'h0);
        check("rstmid_data", memData[0], 32'h0);
        rst = 1'b1;
        txn(0, 0, 32'h0000_0100, 32'h0, 0, 16'h0, rd, rAt, bc);
        check("rd100_kept", rd, 32'hDEAD_BEEF);

        // LATENCY=1 instance
        txn(1, 1, 32'h0000_0100, 32'h0BAD_F00D, 0, 16'h0, rd, rAt, bc);
        check("l1_readyAt", rAt, 2);
        check("l1_busyCycles", bc, 2);
        txn(1, 1, 32'h0000_0104, 32'h600D_CAFE, 0, 16'h0, rd, rAt, bc);
        txn(1, 0, 32'h0000_0104, 32'h0, 0, 16'h0, rd, rAt, bc);
        check("l1_rd104", rd, 32'h600D_CAFE);

        // Continuous request with the address toggling during WAIT
        begin
            int prevReady;
            int pulses;
            logic [31:0] want;
            prevReady = -1;
            pulses    = 0;
            @(negedge clk);
            memReq[1] = 1'b1; memWe[1] = 1'b0; memAddr[1] = 32'h0000_0100;
            for (int n = 1; n <= 12; n++) begin
                @(negedge clk);
                memAddr[1] = (n % 2 == 1) ? 32'h0000_0104 : 32'h0000_0100;
                if (memReady[1]) begin
                    pulses++;
                    want = (pulses % 2 == 1) ? 32'h0BAD_F00D : 32'h600D_CAFE;
                    check($sformatf("hold_data%0d", pulses), memData[1], want);
                    if (prevReady >= 0) check($sformatf("hold_gap%0d", pulses), n - prevReady, 3);
                    prevReady = n;
                    $display("txn inst=1 we=0 held rdata=%h readyAt=%0d", memData[1], n);
                end
            end
            memReq[1] = 1'b0;
            check("hold_pulses", pulses, 4);
        end
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

endmodule
